e1_rx_wb_packer: RTL and testbench

//  Upstream E1 RX stage feeding the E1 Wishbone port of the IO buffer block.

---
 rtl/e1_rx_wb_packer.sv | 222 ++++++++++++++++++++++
 tb/tb_e1_rx_wb_packer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e1_rx_wb_packer.sv
// E1 RX timeslot packer: four timeslot bytes per 32-bit word, written to SPRAM
// over Wishbone through a small word FIFO, with multiframe-done signalling.
module e1_rx_wb_packer #(
    parameter int MFW      = 7,
    parameter int AW       = 14,
    parameter int FIFO_LOG = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic [7:0]     in_data,
    input  logic [4:0]     in_ts,
    input  logic [3:0]     in_frame,
    input  logic [MFW-1:0] in_mf,
    input  logic           in_valid,
    output logic [AW-1:0]  wb_addr,
    output logic [31:0]    wb_wdata,
    output logic [3:0]     wb_wmsk,
    output logic           wb_we,
    output logic           wb_cyc,
    input  logic           wb_ack,
    output logic           mf_done,
    output logic [MFW-1:0] mf_done_idx,
    output logic           err_seq,
    output logic           err_ovf,
    input  logic           err_clr
);

    localparam int DEPTH = 1 << FIFO_LOG;
    localparam int EW    = AW + 33;

    typedef enum logic {
        S_IDLE,
        S_CYC
    } state_e;

    // Packer state
    logic [1:0]    exp_pos_q, exp_pos_d;
    logic [23:0]   part_q, part_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          last_q, last_d;

    // Word FIFO: entry = {last, addr, data}
    logic [EW-1:0]       mem_q [DEPTH];
    logic [FIFO_LOG-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_LOG-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_LOG:0]   cnt_q, cnt_d;

    logic err_seq_q, err_seq_d;
    logic err_ovf_q, err_ovf_d;

    // Wishbone master
    state_e         state_q;
    logic           wb_cyc_q;
    logic [AW-1:0]  wb_addr_q;
    logic [31:0]    wb_wdata_q;
    logic           cur_last_q;
    logic           mf_done_q;
    logic [MFW-1:0] mf_done_idx_q;

    logic [1:0]    pos;
    logic          seq_set;
    logic          push;
    logic          push_ok;
    logic          pop;
    logic          full;
    logic          empty;
    logic [EW-1:0] push_entry;
    logic [EW-1:0] head;

    assign pos   = in_ts[1:0];
    assign full  = (cnt_q == DEPTH[FIFO_LOG:0]);
    assign empty = (cnt_q == '0);
    assign pop   = (state_q == S_CYC) && wb_ack;
    assign head  = mem_q[rd_ptr_q];

    assign push_entry = {last_q, addr_q, in_data, part_q};

    always_comb begin
        exp_pos_d = exp_pos_q;
        part_d    = part_q;
        addr_d    = addr_q;
        last_d    = last_q;
        seq_set   = 1'b0;
        push      = 1'b0;
        if (!enable) begin
            exp_pos_d = 2'd0;
            part_d    = '0;
        end else if (in_valid) begin
            if (pos != exp_pos_q) begin
                seq_set = 1'b1;
            end
            if (pos == exp_pos_q || pos == 2'd0) begin
                unique case (pos)
                    2'd0: begin
                        part_d    = {16'h0, in_data};
                        addr_d    = {in_mf, in_frame, in_ts[4:2]};
                        last_d    = (in_frame == 4'hF) && (in_ts[4:2] == 3'h7);
                        exp_pos_d = 2'd1;
                    end
                    2'd1: begin
                        part_d[15:8] = in_data;
                        exp_pos_d    = 2'd2;
                    end
                    2'd2: begin
                        part_d[23:16] = in_data;
                        exp_pos_d     = 2'd3;
                    end
                    2'd3: begin
                        push      = 1'b1;
                        exp_pos_d = 2'd0;
                    end
                endcase
            end else begin
                // Mid-word gap: drop the partial word and hunt for pos 0
                part_d    = '0;
                exp_pos_d = 2'd0;
            end
        end
    end

    always_comb begin
        push_ok  = push && (!full || pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push_ok && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
        err_seq_d = (err_seq_q && !err_clr) || seq_set;
        err_ovf_d = (err_ovf_q && !err_clr) || (push && !push_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_pos_q <= 2'd0;
            part_q    <= '0;
            addr_q    <= '0;
            last_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            err_seq_q <= 1'b0;
            err_ovf_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            exp_pos_q <= exp_pos_d;
            part_q    <= part_d;
            addr_q    <= addr_d;
            last_q    <= last_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            err_seq_q <= err_seq_d;
            err_ovf_q <= err_ovf_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_entry;
            end
        end
    end

    // Head stays in the FIFO until acked, so a stalled cycle occupies a slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            wb_cyc_q      <= 1'b0;
            wb_addr_q     <= '0;
            wb_wdata_q    <= '0;
            cur_last_q    <= 1'b0;
            mf_done_q     <= 1'b0;
            mf_done_idx_q <= '0;
        end else begin
            mf_done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (!empty) begin
                        state_q    <= S_CYC;
                        wb_cyc_q   <= 1'b1;
                        wb_addr_q  <= head[AW+31:32];
                        wb_wdata_q <= head[31:0];
                        cur_last_q <= head[AW+32];
                    end
                end
                S_CYC: begin
                    if (wb_ack) begin
                        state_q  <= S_IDLE;
                        wb_cyc_q <= 1'b0;
                        if (cur_last_q) begin
                            mf_done_q     <= 1'b1;
                            mf_done_idx_q <= wb_addr_q[AW-1:7];
                        end
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    wb_cyc_q <= 1'b0;
                end
            endcase
        end
    end

    assign wb_cyc      = wb_cyc_q;
    assign wb_we       = wb_cyc_q;
    assign wb_wmsk     = 4'h0;
    assign wb_addr     = wb_addr_q;
    assign wb_wdata    = wb_wdata_q;
    assign mf_done     = mf_done_q;
    assign mf_done_idx = mf_done_idx_q;
    assign err_seq     = err_seq_q;
    assign err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_e1_rx_wb_packer.sv
// Bench for e1_rx_wb_packer: vector table plus corner sequences, with an
// expected-write queue checked whenever the bench acknowledges a cycle.
module tb_e1_rx_wb_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [7:0]  in_data;
    logic [4:0]  in_ts;
    logic [3:0]  in_frame;
    logic [6:0]  in_mf;
    logic        in_valid;
    logic [13:0] wb_addr;
    logic [31:0] wb_wdata;
    logic [3:0]  wb_wmsk;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_ack;
    logic        mf_done;
    logic [6:0]  mf_done_idx;
    logic        err_seq;
    logic        err_ovf;
    logic        err_clr;

    always #5 clk = ~clk;

    e1_rx_wb_packer #(.MFW(7), .AW(14), .FIFO_LOG(2)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .in_data(in_data), .in_ts(in_ts), .in_frame(in_frame),
        .in_mf(in_mf), .in_valid(in_valid),
        .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_wmsk(wb_wmsk),
        .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack),
        .mf_done(mf_done), .mf_done_idx(mf_done_idx),
        .err_seq(err_seq), .err_ovf(err_ovf), .err_clr(err_clr)
    );

    typedef struct {
        logic [6:0]  mf;
        logic [3:0]  fr;
        logic [2:0]  tsw;
        logic [31:0] data;
        logic [13:0] exp_addr;
    } vec_t;

    typedef struct {
        logic [13:0] a;
        logic [31:0] d;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[5];
    int   checks;
    int   errors;
    int   writes;
    int   mf_cnt;
    int   max_wait;
    bit   ack_hold;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [6:0] mf, input logic [3:0] fr,
                             input logic [4:0] ts, input logic [7:0] d);
        @(negedge clk);
        in_mf    = mf;
        in_frame = fr;
        in_ts    = ts;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [6:0] mf, input logic [3:0] fr,
                             input logic [2:0] tsw, input logic [31:0] d,
                             input bit expect_write);
        exp_t e;
        if (expect_write) begin
            e.a = {mf, fr, tsw};
            e.d = d;
            sb.push_back(e);
        end
        for (int b = 0; b < 4; b++) begin
            logic [1:0] p;
            p = b[1:0];
            send_byte(mf, fr, {tsw, p}, d[8*b +: 8]);
        end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !wb_cyc) break;
        end
        chk(name, sb.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        int w0;
        int m0;
        logic [31:0] rnd;

        tbl[0] = '{7'd5,   4'd0,  3'd0, 32'h44332211, 14'h0280};
        tbl[1] = '{7'd0,   4'd0,  3'd0, 32'hDEADBEEF, 14'h0000};
        tbl[2] = '{7'd127, 4'd15, 3'd7, 32'h01020304, 14'h3FFF};
        tbl[3] = '{7'd1,   4'd3,  3'd2, 32'h80FF007F, 14'h009A};
        tbl[4] = '{7'd42,  4'd9,  3'd5, 32'hA5A55A5A, 14'h154D};

        checks   = 0;
        errors   = 0;
        writes   = 0;
        mf_cnt   = 0;
        max_wait = 0;
        ack_hold = 1'b0;
        rst_n    = 1'b0;
        enable   = 1'b0;
        in_data  = '0;
        in_ts    = '0;
        in_frame = '0;
        in_mf    = '0;
        in_valid = 1'b0;
        err_clr  = 1'b0;
        wb_ack   = 1'b0;

        fork
            begin : monitor
                exp_t e;
                int   wait_cnt;
                bit   chk_gap;
                wait_cnt = 0;
                chk_gap  = 0;
                forever begin
                    @(negedge clk);
                    if (mf_done) mf_cnt++;
                    if (chk_gap) begin
                        chk("cyc_gap", wb_cyc, 0);
                        chk_gap = 0;
                    end
                    if (!rst_n || ack_hold || !wb_cyc) begin
                        wb_ack   = 1'b0;
                        wait_cnt = $urandom_range(0, max_wait);
                    end else if (!wb_ack) begin
                        if (wait_cnt == 0) begin
                            wb_ack = 1'b1;
                            writes++;
                            chk("wmsk", wb_wmsk, 0);
                            chk("we", wb_we, 1);
                            if (sb.size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                                         wb_addr, wb_wdata);
                            end else begin
                                e = sb.pop_front();
                                chk("wb_addr", wb_addr, e.a);
                                chk("wb_wdata", wb_wdata, e.d);
                            end
                            chk_gap = 1;
                        end else begin
                            wait_cnt--;
                        end
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_cyc", wb_cyc, 0);
        chk("rst_we", wb_we, 0);
        chk("rst_addr", wb_addr, 0);
        chk("rst_wdata", wb_wdata, 0);
        chk("rst_mf_done", mf_done, 0);
        chk("rst_mf_idx", mf_done_idx, 0);
        chk("rst_err_seq", err_seq, 0);
        chk("rst_err_ovf", err_ovf, 0);
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (2) @(negedge clk);

        // Vector table, immediate ack
        for (int i = 0; i < 5; i++) begin
            exp_t e;
            e.a = tbl[i].exp_addr;
            e.d = tbl[i].data;
            sb.push_back(e);
            for (int b = 0; b < 4; b++) begin
                logic [1:0] p;
                p = b[1:0];
                send_byte(tbl[i].mf, tbl[i].fr, {tbl[i].tsw, p},
                          tbl[i].data[8*b +: 8]);
            end
            wait_idle("tbl_drain");
        end
        chk("tbl_writes", writes, 5);
        chk("tbl_mf_done_cnt", mf_cnt, 1);
        chk("tbl_mf_done_idx", mf_done_idx, 127);
        chk("tbl_err_seq", err_seq, 0);

        // Full multiframe, random ack latency
        max_wait = 3;
        w0 = writes;
        m0 = mf_cnt;
        for (int f = 0; f < 16; f++) begin
            for (int t = 0; t < 8; t++) begin
                rnd = $urandom;
                send_word(7'd5, f[3:0], t[2:0], rnd, 1);
            end
        end
        wait_idle("mf_drain");
        chk("mf_writes", writes - w0, 128);
        chk("mf_done_cnt", mf_cnt - m0, 1);
        chk("mf_done_idx", mf_done_idx, 5);
        chk("mf_err_ovf", err_ovf, 0);
        max_wait = 0;

        // Overflow: ack stalled while five words arrive
        ack_hold = 1'b1;
        for (int t = 0; t < 5; t++) begin
            send_word(7'd9, 4'd2, t[2:0], 32'h0BAD0000 + t, t < 4);
        end
        repeat (3) @(negedge clk);
        chk("ovf_set", err_ovf, 1);
        w0 = writes;
        ack_hold = 1'b0;
        wait_idle("ovf_drain");
        chk("ovf_writes", writes - w0, 4);
        pulse_clr();
        chk("ovf_clr", err_ovf, 0);

        // Sequence gap: ts 0,1,3 then 4..7
        w0 = writes;
        begin
            exp_t e;
            e.a = 14'h0121;
            e.d = 32'hD7C6B5A4;
            sb.push_back(e);
        end
        send_byte(7'd2, 4'd4, 5'd0, 8'h10);
        send_byte(7'd2, 4'd4, 5'd1, 8'h11);
        send_byte(7'd2, 4'd4, 5'd3, 8'h13);
        send_byte(7'd2, 4'd4, 5'd4, 8'hA4);
        send_byte(7'd2, 4'd4, 5'd5, 8'hB5);
        send_byte(7'd2, 4'd4, 5'd6, 8'hC6);
        send_byte(7'd2, 4'd4, 5'd7, 8'hD7);
        wait_idle("seq_drain");
        chk("seq_writes", writes - w0, 1);
        chk("seq_set", err_seq, 1);
        pulse_clr();
        chk("seq_clr", err_seq, 0);

        // Clear and set in the same cycle: set wins
        @(negedge clk);
        in_ts    = 5'd1;
        in_valid = 1'b1;
        err_clr  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        err_clr  = 1'b0;
        chk("seq_set_wins", err_seq, 1);
        pulse_clr();
        chk("seq_clr2", err_seq, 0);

        // Enable drop with a word pending in the FIFO
        w0 = writes;
        ack_hold = 1'b1;
        send_word(7'd3, 4'd5, 3'd7, 32'hCAFEF00D, 1);
        send_byte(7'd3, 4'd6, 5'd0, 8'h61);
        send_byte(7'd3, 4'd6, 5'd1, 8'h62);
        enable   = 1'b0;
        ack_hold = 1'b0;
        send_byte(7'd3, 4'd6, 5'd2, 8'h63);
        send_byte(7'd3, 4'd6, 5'd3, 8'h64);
        enable = 1'b1;
        send_word(7'd3, 4'd6, 3'd1, 32'h78563412, 1);
        wait_idle("en_drain");
        chk("en_writes", writes - w0, 2);
        chk("en_err_seq", err_seq, 0);

        // Async reset during an open cycle
        ack_hold = 1'b1;
        send_word(7'd4, 4'd0, 3'd0, 32'h12345678, 0);
        for (int i = 0; i < 20; i++) begin
            if (wb_cyc) break;
            @(negedge clk);
        end
        chk("rst_pre_cyc", wb_cyc, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst_async_cyc", wb_cyc, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        ack_hold = 1'b0;
        w0 = writes;
        repeat (10) @(negedge clk);
        chk("rst_fifo_empty", wb_cyc, 0);
        chk("rst_no_write", writes - w0, 0);
        send_word(7'd4, 4'd0, 3'd1, 32'h9ABCDEF0, 1);
        wait_idle("post_rst_drain");
        chk("post_rst_writes", writes - w0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
